// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one FIFO write port.
// A requester keeps ownership for at most MAX_BURST accepted words or until it
// drops valid. On release the next owner is chosen in the same cycle, so
// back-to-back grants carry no idle bubble.
//
// Ports
//   wr_clk      in   1                    clock (FIFO write domain)
//   rst         in   1                    synchronous active-high reset
//   req_valid   in   NUM_REQ              per-requester word available
//   req_data    in   NUM_REQ*DATA_WIDTH   requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   out  NUM_REQ              word of that requester accepted this cycle
//   grant       out  NUM_REQ              one-hot owner, 0 when idle (registered)
//   busy        out  1                    high while a grant is held (registered)
//   wr_en       out  1                    FIFO write enable
//   data_in     out  DATA_WIDTH           FIFO write data
//   full        in   1                    FIFO full flag
//   xfer_count  out  16                   words written since reset, wraps
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          full,
    output logic [15:0]                   xfer_count
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Circular search from start; returns {found, index}. Iterating from the
    // far end lets the nearest valid requester overwrite earlier hits.
    function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [OW-1:0]      start);
        logic [OW:0] res;
        int          idx;
        res = {(OW+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (valid[OW'(idx)]) begin
                res = {1'b1, OW'(idx)};
            end
        end
        return res;
    endfunction

    state_t                state_r;
    logic [OW-1:0]         owner_r;
    logic [OW-1:0]         rr_ptr_r;
    logic [BW-1:0]         beat_r;
    logic [15:0]           xfer_count_r;
    logic [NUM_REQ-1:0]    grant_r;
    logic                  busy_r;

    logic                  active_s;
    logic                  xfer_s;
    logic                  release_s;
    logic [OW-1:0]         next_ptr_s;
    logic [OW-1:0]         arb_start_s;
    logic [OW:0]           pick_s;
    logic                  pick_found_s;
    logic [OW-1:0]         pick_idx_s;
    logic [NUM_REQ-1:0]    pick_onehot_s;
    logic [DATA_WIDTH-1:0] data_sel_s;

    // Transfer/release decode, arbitration and the combinational FIFO-side outputs.
    always_comb begin
        // Reset masks every write-side output in the same cycle.
        active_s   = (state_r == ST_GRANT) && !rst;
        xfer_s     = active_s && req_valid[owner_r] && !full;
        // Release on the burst-completing beat or as soon as the owner goes idle;
        // full by itself never releases.
        release_s  = active_s &&
                     ((xfer_s && (beat_r == BW'(MAX_BURST - 1))) || !req_valid[owner_r]);
        next_ptr_s = (owner_r == OW'(NUM_REQ - 1)) ? {OW{1'b0}} : (owner_r + OW'(1));
        // In GRANT the only arbitration that matters is the release one, which
        // starts just past the current owner; IDLE starts from rr_ptr.
        arb_start_s   = (state_r == ST_GRANT) ? next_ptr_s : rr_ptr_r;
        pick_s        = rr_pick(req_valid, arb_start_s);
        pick_found_s  = pick_s[OW];
        pick_idx_s    = pick_s[OW-1:0];
        pick_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;

        data_sel_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            data_sel_s = data_sel_s |
                         (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{owner_r == OW'(i)}});
        end

        req_ready = grant_r & {NUM_REQ{active_s && !full}};
        wr_en     = xfer_s;
        data_in   = active_s ? data_sel_s : {DATA_WIDTH{1'b0}};
    end

    // Arbiter FSM with registered grant/busy and the word counter.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= {OW{1'b0}};
            rr_ptr_r     <= {OW{1'b0}};
            beat_r       <= {BW{1'b0}};
            xfer_count_r <= 16'd0;
            grant_r      <= {NUM_REQ{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r <= ST_GRANT;
                        owner_r <= pick_idx_s;
                        beat_r  <= {BW{1'b0}};
                        grant_r <= pick_onehot_s;
                        busy_r  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (xfer_s) begin
                        xfer_count_r <= xfer_count_r + 16'd1;
                    end
                    if (release_s) begin
                        rr_ptr_r <= next_ptr_s;
                        if (pick_found_s) begin
                            // Hand over without leaving GRANT.
                            owner_r <= pick_idx_s;
                            beat_r  <= {BW{1'b0}};
                            grant_r <= pick_onehot_s;
                        end else begin
                            state_r <= ST_IDLE;
                            beat_r  <= {BW{1'b0}};
                            grant_r <= {NUM_REQ{1'b0}};
                            busy_r  <= 1'b0;
                        end
                    end else if (xfer_s) begin
                        beat_r <= beat_r + BW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= {NUM_REQ{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = grant_r;
    assign busy       = busy_r;
    assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed scenarios followed by a randomized run. A transaction-level model
// (owner / words-in-burst / search pointer as plain integers) predicts every
// output each cycle; each requester's word stream is a numbered sequence so a
// lost or duplicated word shows up as a data mismatch.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic               wr_clk;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      grant;
    logic               busy;
    logic               wr_en;
    logic [DW-1:0]      data_in;
    logic               full;
    logic [15:0]        xfer_count;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .grant      (grant),
        .busy       (busy),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .full       (full),
        .xfer_count (xfer_count)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [NR-1:0] act;
    logic        full_v;
    logic        rst_v;
    int          sent [NR];
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_words;
    int          m_count;
    int          dut_wr_cnt;
    int          gseq [$];
    logic [NR-1:0] last_grant;
    int          w0;
    int          rr_exp [5] = '{1, 2, 4, 8, 1};

    function automatic logic [7:0] gen(input int i, input int n);
        return 8'((i * 61 + n * 13 + 5) % 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input int start);
        for (int k = 0; k < NR; k++) begin
            if (act[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    task automatic drive();
        rst  = rst_v;
        full = full_v;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]        = act[i];
            req_data[i*DW +: DW] = gen(i, sent[i]);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_words = 0; m_count = 0;
    endtask

    // Advance the model across one clock edge using the inputs just driven.
    task automatic model_edge();
        int w;
        if (rst_v) begin
            model_reset();
        end else if (!m_busy) begin
            w = first_from(m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_words = 0;
            end
        end else begin
            if (act[m_owner] && !full_v) begin
                m_count = (m_count + 1) % 65536;
                m_words++;
                sent[m_owner]++;
            end
            if (m_words == MB || !act[m_owner]) begin
                m_ptr = (m_owner + 1) % NR;
                w = first_from(m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_words = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    // One cycle: drive, compare everything against the model, take the edge.
    task automatic tick();
        logic [31:0] e_grant, e_ready, e_data;
        logic        e_wr;
        drive();
        #3;
        e_grant = m_busy ? (32'd1 << m_owner) : 32'd0;
        e_ready = (m_busy && !full_v && !rst_v) ? (32'd1 << m_owner) : 32'd0;
        e_wr    = m_busy && !rst_v && !full_v && act[m_owner];
        e_data  = (m_busy && !rst_v) ? 32'(gen(m_owner, sent[m_owner])) : 32'd0;
        check("grant",      32'(grant),      e_grant);
        check("busy",       32'(busy),       32'(m_busy));
        check("req_ready",  32'(req_ready),  e_ready);
        check("wr_en",      32'(wr_en),      32'(e_wr));
        check("data_in",    32'(data_in),    e_data);
        check("xfer_count", 32'(xfer_count), 32'(m_count));
        check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        if (wr_en === 1'b1) dut_wr_cnt++;
        if (grant !== last_grant && grant !== 4'b0000) gseq.push_back(int'(grant));
        last_grant = grant;
        @(posedge wr_clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) sent[i] = 0;
        dut_wr_cnt = 0;
        last_grant = 4'b0000;
        model_reset();

        // Power-up reset with every requester valid: outputs must stay gated.
        act = 4'b1111; full_v = 1'b0; rst_v = 1'b1;
        drive();
        @(posedge wr_clk);
        #1;
        check("rst_ready",  32'(req_ready),  32'd0);
        check("rst_wr_en",  32'(wr_en),      32'd0);
        check("rst_data",   32'(data_in),    32'd0);
        check("rst_grant",  32'(grant),      32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_count",  32'(xfer_count), 32'd0);
        rst_v = 1'b0;

        // Single requester for 10 cycles: 9 writes, regrant without bubble.
        act = 4'b0001;
        w0 = dut_wr_cnt;
        tick();
        check("single_grant_c1", 32'(grant), 32'd1);
        repeat (9) tick();
        check("single_wr_pulses", 32'(dut_wr_cnt - w0), 32'd9);
        check("single_count",     32'(xfer_count),      32'd9);
        act = 4'b0000;
        tick();

        // Round robin with all four valid.
        do_reset();
        act = 4'b1111;
        gseq.delete();
        last_grant = 4'b0000;
        w0 = dut_wr_cnt;
        repeat (21) tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_seq%0d", i), (gseq.size() > i) ? 32'(gseq[i]) : 32'hFFFF_FFFF,
                  32'(rr_exp[i]));
        end
        check("rr_wr_continuous", 32'(dut_wr_cnt - w0), 32'd20);

        // Full stall at beat 2, then two more beats and hand-over to req 1.
        do_reset();
        act = 4'b0011;
        repeat (3) tick();
        full_v = 1'b1;
        w0 = dut_wr_cnt;
        repeat (5) tick();
        check("stall_no_wr", 32'(dut_wr_cnt - w0), 32'd0);
        check("stall_grant", 32'(grant),            32'd1);
        full_v = 1'b0;
        w0 = dut_wr_cnt;
        repeat (2) tick();
        check("stall_resume_wr", 32'(dut_wr_cnt - w0), 32'd2);
        check("stall_release",   32'(grant),            32'd2);

        // Owner 2 drops valid after one beat while req 3 waits.
        do_reset();
        act = 4'b1100;
        repeat (2) tick();
        act = 4'b1000;
        tick();
        check("drop_grant", 32'(grant), 32'd8);
        drive();
        #1;
        check("drop_data", 32'(data_in), 32'(gen(3, sent[3])));
        tick();

        // Reset during owner 1 beat 2, then req 1 wins over req 3.
        do_reset();
        act = 4'b0010;
        repeat (3) tick();
        act = 4'b1010;
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        check("midrst_grant", 32'(grant),      32'd0);
        check("midrst_count", 32'(xfer_count), 32'd0);
        tick();
        check("midrst_regrant", 32'(grant), 32'd2);

        // Randomized traffic, back-pressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) act = 4'($urandom);
            full_v = ($urandom_range(0, 4) == 0);
            rst_v  = ($urandom_range(0, 249) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH  8  FIFO word width
  NUM_REQ     4  number of requesters
  MAX_BURST   4  max beats per grant, >=1
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  wr_clk     in   1                     single clock, FIFO write domain
  rst        in   1                     reset
  req_valid  in   NUM_REQ               per-requester word available
  req_data   in   NUM_REQ*DATA_WIDTH    requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
  req_ready  out  NUM_REQ               per-requester word accepted this cycle
  grant      out  NUM_REQ               one-hot current owner, 0 when idle
  busy       out  1                     high in GRANT state
  wr_en      out  1                     FIFO write enable
  data_in    out  DATA_WIDTH            FIFO write data
  full       in   1                     FIFO full flag
  xfer_count out  16                    total words written, wraps
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 All state SHALL update on posedge wr_clk only.

Function
REQ-005 State SHALL be: FSM {IDLE, GRANT}, owner index, rr_ptr (next search start), beat counter of width clog2(MAX_BURST+1), and xfer_count.
REQ-006 A transfer SHALL occur in a cycle iff state==GRANT, req_valid[owner]==1, full==0 and rst==0.
REQ-007 req_ready[i] SHALL be combinational: 1 iff i==owner, state==GRANT, full==0 and rst==0; all other bits 0.
REQ-008 wr_en SHALL equal the transfer condition; data_in SHALL be req_data of owner in GRANT, 0 in IDLE.
REQ-009 Arbitration SHALL select the first i with req_valid[i]==1, searching circularly from rr_ptr.
REQ-010 IDLE: if any req_valid, arbitrate, load owner, beat=0, go to GRANT at the next edge; first transfer is possible the cycle after the request (1-cycle grant latency).
REQ-011 GRANT: each transfer SHALL increment beat and xfer_count (mod 2^16).
REQ-012 Release SHALL occur when the transfer takes beat to MAX_BURST, or when req_valid[owner]==0 in a GRANT cycle.
REQ-013 On release, rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-014 On release, arbitration from the new rr_ptr SHALL run in the same cycle: if a winner exists, owner=winner, beat=0 and state stays GRANT (no bubble); otherwise go to IDLE.
REQ-015 The old owner SHALL be regranted back-to-back only if it is the sole valid requester.
REQ-016 full==1 SHALL stall: no transfer, beat holds, grant held; full alone never causes release.
REQ-017 Owner dropping valid while full==1 SHALL release per REQ-012.
REQ-018 The last beat and other requesters asserting valid in the same cycle SHALL follow REQ-014; no word is lost or duplicated.
REQ-019 grant SHALL be onehot(owner) in GRANT and 0 in IDLE; at most one req_ready bit is ever high.
REQ-020 Requester contract: req_data is held stable while req_valid==1 and req_ready==0.

Reset
REQ-021 With rst high at an edge, the block SHALL enter: state=IDLE, owner=0, rr_ptr=0, beat=0, xfer_count=0, grant=0, busy=0.
REQ-022 While rst is high, req_ready=0, wr_en=0 and data_in=0, combinationally.
REQ-023 Reset mid-burst SHALL abort the grant with no write in the reset cycle; arbitration restarts from requester 0 after rst falls.

Verification
REQ-024 Single requester: req_valid=0001 for 10 cycles, full=0, MAX_BURST=4 -> grant=0001 from cycle 1; 9 wr_en pulses; beat wraps after each 4 with regrant and no bubble; xfer_count=9.
REQ-025 Round-robin: all four valid continuously, full=0 -> grant sequence 0001,0010,0100,1000,0001; 4 beats each; wr_en continuously high after the first grant cycle.
REQ-026 Full stall: owner 0 mid-burst at beat=2, full=1 for 5 cycles -> wr_en=0, req_ready=0, grant stays 0001 and beat stays 2; full=0 -> 2 more beats, then release.
REQ-027 Early drop: owner 2 drops valid after 1 beat while req 3 is valid -> next edge grant=1000 and rr_ptr=3; data_in switches to req_data[3].
REQ-028 Reset mid-burst: rst=1 for 1 cycle during owner 1 beat 2 -> wr_en=0 that cycle; then IDLE with grant=0 and xfer_count=0; req 1 and req 3 valid -> req 1 granted first.
REQ-029 Scoreboard on all tests: FIFO write stream equals the per-requester order of accepted words; grant is never multi-hot.
